// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, shift-mode encodings and the shifter stage payload
package alu_pkg;
    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int TAG_W   = 5;
    localparam logic SHIFT_LOGICAL = 1'b0;
    localparam logic SHIFT_ARITH   = 1'b1;
    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [SHAMT_W-1:0] shamt;
        logic               arith;
        logic [TAG_W-1:0]   tag;
    } shift_pay_t;
endpackage

// File: rtl/shift_right_stage.sv
// shift_right_stage: one elastic register slice applying a conditional right shift by SHIFT
module shift_right_stage
    import alu_pkg::*;
#(
    parameter int SHIFT    = 16,
    parameter int CTRL_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       up_valid_i,
    input  shift_pay_t up_pay_i,
    input  logic       dn_accept_i,
    output logic       accept_o,
    output logic       valid_o,
    output shift_pay_t pay_o
);
    logic       valid_q;
    shift_pay_t pay_q, pay_d;
    logic       fill;
    always_comb begin
        fill = (up_pay_i.arith == SHIFT_ARITH) && up_pay_i.data[DATA_W-1];
        pay_d = up_pay_i;
        pay_d.data = up_pay_i.shamt[CTRL_BIT] ? {{SHIFT{fill}}, up_pay_i.data[DATA_W-1:SHIFT]} : up_pay_i.data;
    end
    assign accept_o = !valid_q || dn_accept_i;
    assign valid_o  = valid_q;
    assign pay_o    = pay_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept_o) begin
            valid_q <= up_valid_i;
            if (up_valid_i) pay_q <= pay_d;
        end
    end
endmodule

// File: rtl/shift_right_pipe.sv
// shift_right_pipe: five-stage elastic 32-bit right barrel shifter (SRL/SRA) with tag and flush
module shift_right_pipe
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [4:0]        in_shamt,
    input  logic              in_arith,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag
);
    logic [5:0] v, acc;
    shift_pay_t pay [6];
    logic       unused_pay;
    assign v[0]     = in_valid;
    assign pay[0]   = '{data: in_data, shamt: in_shamt, arith: in_arith, tag: in_tag};
    assign acc[5]   = out_ready;
    assign in_ready = acc[0] && !flush;
    // stage k handles shamt bit 4-k, i.e. shift distances 16, 8, 4, 2, 1
    for (genvar k = 0; k < 5; k++) begin : g_stage
        shift_right_stage #(.SHIFT(16 >> k), .CTRL_BIT(4 - k)) u_stage (
            .clk(clk),
            .rst_n(rst_n),
            .flush(flush),
            .up_valid_i(v[k]),
            .up_pay_i(pay[k]),
            .dn_accept_i(acc[k+1]),
            .accept_o(acc[k]),
            .valid_o(v[k+1]),
            .pay_o(pay[k+1])
        );
    end
    assign out_valid  = v[5];
    assign out_data   = pay[5].data;
    assign out_tag    = pay[5].tag;
    assign unused_pay = ^{pay[5].shamt, pay[5].arith};
endmodule

// File: tb/tb_shift_right_pipe.sv
// tb_shift_right_pipe: directed vectors plus a scoreboarded random run for shift_right_pipe
module tb_shift_right_pipe;
    import alu_pkg::*;
    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_arith = 0, out_ready = 1;
    logic [31:0] in_data = 0;
    logic [4:0]  in_shamt = 0, in_tag = 0;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    int          n_cmp = 0, n_err = 0;
    bit          sb_en = 0, fired = 0;
    logic [36:0] q [$];

    always #5 clk = ~clk;

    shift_right_pipe #(.DATA_W(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_arith(in_arith), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic a);
        if (a) return $unsigned($signed(d) >>> s);
        return d >> s;
    endfunction

    task automatic put(input logic [31:0] d, input logic [4:0] s, input logic a, input logic [4:0] t);
        in_data = d; in_shamt = s; in_arith = a; in_tag = t; in_valid = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) chk("put_accept", in_ready, 1);
        @(posedge clk); #1 in_valid = 0;
    endtask

    task automatic op_chk(input string name, input logic [31:0] d, input logic [4:0] s, input logic a,
                          input logic [4:0] t, input logic [31:0] exp);
        put(d, s, a, t);
        repeat (3) @(negedge clk);
        @(negedge clk); chk({name, "_early"}, out_valid, 0);
        @(negedge clk);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_data"}, out_data, exp);
        chk({name, "_tag"}, out_tag, t);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) if (sb_en) begin
        fired = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("sb_spurious", q.size(), 1);
            else chk("sb_result", {out_tag, out_data}, q.pop_front());
        end
        if (flush) q.delete();
        if (fired) q.push_back({in_tag, ref_shift(in_data, in_shamt, in_arith)});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] sd [5] = '{32'hF000_0000, 32'hF000_0000, 32'h0000_FF00, 32'h8765_4321, 32'h8765_4321};
    logic [4:0]  ss [5] = '{5'd4, 5'd4, 5'd8, 5'd1, 5'd28};
    logic        sa [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] sx [5] = '{32'hFF00_0000, 32'h0F00_0000, 32'h0000_00FF, 32'h43B2_A190, 32'hFFFF_FFF8};

    initial begin
        int cnt;
        repeat (2) @(posedge clk); #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_tag", out_tag, 0);
        rst_n = 1;
        @(negedge clk); chk("rst_ready", in_ready, 1);
        @(posedge clk); #1;

        op_chk("srl16", 32'h1234_5678, 5'd16, SHIFT_LOGICAL, 5'd3, 32'h0000_1234);
        op_chk("sra31", 32'h8000_0000, 5'd31, SHIFT_ARITH, 5'd7, 32'hFFFF_FFFF);
        op_chk("srl31", 32'h8000_0000, 5'd31, SHIFT_LOGICAL, 5'd8, 32'h0000_0001);
        op_chk("sra0", 32'h8000_0000, 5'd0, SHIFT_ARITH, 5'd9, 32'h8000_0000);

        out_ready = 0;
        for (int i = 0; i < 5; i++) put(sd[i], ss[i], sa[i], 5'(i + 1));
        @(negedge clk);
        chk("full_ready", in_ready, 0);
        chk("full_valid", out_valid, 1);
        chk("full_tag", out_tag, 1);
        repeat (3) @(negedge clk);
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, sx[0]);
        chk("stall_tag", out_tag, 1);
        @(posedge clk); #1 out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 10; j++) begin
                @(negedge clk);
                if (out_valid) break;
            end
            chk("drain_valid", out_valid, 1);
            chk("drain_tag", out_tag, 5'(k + 1));
            chk("drain_data", out_data, sx[k]);
        end
        @(negedge clk); chk("no_dup", out_valid, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) put(32'h1111_0000 << i, 5'd2, SHIFT_LOGICAL, 5'(20 + i));
        flush = 1; in_data = 32'hCAFE_F00D; in_shamt = 5'd3; in_tag = 5'd30; in_valid = 1;
        @(negedge clk); chk("flush_ready", in_ready, 0);
        @(posedge clk); #1 flush = 0; in_valid = 0;
        cnt = 0;
        repeat (8) begin @(negedge clk); if (out_valid) cnt++; end
        chk("flush_none", cnt, 0);
        @(posedge clk); #1;
        op_chk("post_flush", 32'hA5A5_A5A5, 5'd4, SHIFT_ARITH, 5'd11, 32'hFA5A_5A5A);

        put(32'hDEAD_BEEF, 5'd0, SHIFT_LOGICAL, 5'd4);
        @(posedge clk); #1 rst_n = 0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_tag", out_tag, 0);
        @(negedge clk) rst_n = 1;
        @(negedge clk); chk("arst_ready", in_ready, 1);
        cnt = 0;
        repeat (8) begin @(negedge clk); if (out_valid) cnt++; end
        chk("arst_stale", cnt, 0);
        @(posedge clk); #1;

        fired = 0;
        sb_en = 1;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || fired) begin
                if ($urandom_range(3) != 0) begin
                    in_data = $urandom; in_shamt = 5'($urandom_range(31));
                    in_arith = 1'($urandom_range(1)); in_tag = 5'($urandom_range(31));
                    in_valid = 1;
                end else in_valid = 0;
            end
            out_ready = 1'($urandom_range(1));
            flush = ($urandom_range(99) < 2);
            @(posedge clk); #1;
        end
        flush = 0; in_valid = 0; out_ready = 1;
        repeat (12) @(posedge clk);
        #1 chk("rand_drain", q.size(), 0);
        sb_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
